spi_sensor_master: RTL and testbench
====================================

Name: spi_sensor_master

Overview:
- Single-master SPI engine shared by two sensors: gyroscope (sensor_select=0, SS_G) and accelerometer (sensor_select=1, SS_A).
- Runs a transaction of 1–7 bytes. Byte 0 is the command/address byte. Each later byte is full-duplex: MOSI sends write_data, MISO bytes are returned on read_data with a read_ready strobe.
- Sits between the sensor-polling controller and the board SPI pins. It is clocked by the pre-divided clock div_clk.

Parameters:
- none. SCLK is fixed at div_clk/2, 8-bit bytes, MSB first.

Ports:
- div_clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sensor_select  in  1  0=gyro, 1=accel; sampled with write_start.
- write_start  in  1  1-cycle start request; honoured only when write_ready=1.
- write_data  in  8  byte to transmit; sampled at start of each byte.
- write_count_bytes  in  3  total bytes in the transaction, including byte 0; 0 is ignored.
- write_ready  out  1  high when idle and able to accept write_start.
- read_ready  out  1  1-cycle strobe: read_data holds a new received byte.
- read_data  out  8  last received byte, bytes 1..N-1.
- SCLK  out  1  SPI clock, idle high (CPOL=1, CPHA=1).
- MOSI  out  1  master out.
- MISO_G  in  1  gyro data in.
- SS_G  out  1  gyro select, active low.
- MISO_A  in  1  accel data in.
- SS_A  out  1  accel select, active low.

Behaviour:
- Reset values (any time, including mid-transfer):
  - State IDLE.
  - SCLK=1, SS_G=1, SS_A=1, MOSI=0.
  - write_ready=1, read_ready=0, read_data=0x00.
  - All counters cleared.
- States: IDLE -> XFER -> DONE -> IDLE.
- Start:
  - In IDLE, write_start=1 with write_count_bytes≠0 latches sensor_select, the byte count N and write_data into the TX shift register.
  - Next cycle: state XFER, write_ready=0, and the selected SS goes low. The other SS stays high.
  - write_start while busy, or with count=0, is ignored.
- XFER, per bit: 2 div_clk cycles.
  - Phase A: SCLK=0; MOSI drives the current TX bit, MSB first.
  - Phase B: SCLK=1; at the edge entering phase B, MISO of the latched sensor is shifted into the RX register, MSB first.
  - One byte = 16 cycles. The SS low window is exactly 16*N cycles.
- Byte boundary, k≥1: write_data is resampled into the TX register at the first phase A of byte k.
- Byte completion, k≥1:
  - The cycle after bit 0's phase B: read_data <= RX byte, read_ready=1 for exactly 1 cycle.
  - The RX byte of byte 0 is discarded, so there is no strobe for byte 0.
- After the last byte:
  - State DONE for 1 cycle: SS high, SCLK high; the final read_ready strobe fires here.
  - Then IDLE with write_ready=1.
- Latency: start accepted at edge t -> SS low for cycles t+1..t+16N -> write_ready=1 at t+16N+2.
- sensor_select and MISO of the unselected sensor are ignored during a transfer.
- SCLK is glitch-free and registered. MOSI only changes while SCLK=0 (phase A entry).
- Reset asserted mid-transfer aborts immediately to reset values. No read_ready is emitted.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, XFER, DONE}
  - constants BYTE_W=8, SENSOR_GYRO=0, SENSOR_ACCL=1
- Optional sub-module spi_shift_byte: 8-bit TX/RX shift pair plus bit counter. The top level holds the FSM, byte counter and SS/select mux.

Test Plan:
- Gyro: sensor_select=0, write_data=0xAA, count=2, 1-cycle start -> SS_G low 32 cycles, SS_A stays high, 16 SCLK rising edges, MOSI=10101010 twice. MISO_G driving 0x5C in byte 1 -> read_data=0x5C, one read_ready pulse. write_ready back 34 cycles after start.
- Accel: sensor_select=1, write_data=0xFF, count=5, MISO_A=0xA5 each byte -> SS_A low 80 cycles, MOSI all 1s, exactly 4 read_ready pulses each with read_data=0xA5, SS_G high throughout.
- count=0 with write_start -> no SS activity, write_ready stays 1, SCLK stays 1. count=1 -> one 16-cycle byte, no read_ready.
- write_start re-pulsed mid-transfer with different sensor_select/count -> ignored; the original transfer completes unchanged.
- reset asserted at byte 1, bit 3 -> next cycle SS_G=1, SCLK=1, write_ready=1, no read_ready. A new transfer then runs normally.
- Back-to-back: start on the first cycle write_ready=1 after a gyro transfer -> accel transfer begins next cycle. MISO_G toggling is ignored.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI sensor master.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
    localparam int BYTE_W = 8;
    localparam logic SENSOR_GYRO = 1'b0;
    localparam logic SENSOR_ACCL = 1'b1;
endpackage

// File: rtl/spi_shift_byte.sv
// spi_shift_byte: MSB-first TX/RX shift pair with a half-bit counter.
module spi_shift_byte
    import spi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              miso_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              mosi_o,
    output logic              phase_b_o,
    output logic              byte_end_o,
    output logic [BYTE_W-1:0] rx_o
);
    logic [BYTE_W-1:0] tx_q, rx_q;
    logic [3:0]        cnt_q;

    // Even count = phase A, odd = phase B; TX holds its last bit through the final phase B.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            tx_q  <= data_i;
            cnt_q <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + 4'd1;
            if (!cnt_q[0]) rx_q <= {rx_q[BYTE_W-2:0], miso_i};
            else if (cnt_q != 4'd15) tx_q <= {tx_q[BYTE_W-2:0], 1'b0};
        end
    end

    assign mosi_o     = tx_q[BYTE_W-1];
    assign phase_b_o  = cnt_q[0];
    assign byte_end_o = &cnt_q;
    assign rx_o       = rx_q;
endmodule

// File: rtl/spi_sensor_master.sv
// spi_sensor_master: SPI mode-3 master for a gyro and an accelerometer,
// running 1-7 byte full-duplex transactions with SCLK at div_clk/2.
module spi_sensor_master
    import spi_pkg::*;
(
    input  logic              div_clk,
    input  logic              reset,
    input  logic              sensor_select,
    input  logic              write_start,
    input  logic [BYTE_W-1:0] write_data,
    input  logic [2:0]        write_count_bytes,
    output logic              write_ready,
    output logic              read_ready,
    output logic [BYTE_W-1:0] read_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO_G,
    output logic              SS_G,
    input  logic              MISO_A,
    output logic              SS_A
);
    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [2:0]        nbytes_q, nbytes_d, byte_q, byte_d;
    logic              sclk_q, sclk_d, ss_g_q, ss_g_d, ss_a_q, ss_a_d;
    logic              rready_q, rready_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d, rx;
    logic              start, last_byte, shift_end, byte_end, phase_b, load, miso;

    always_comb begin
        start     = state_q == IDLE && write_start && write_count_bytes != 3'd0;
        last_byte = byte_q == nbytes_q - 3'd1;
        byte_end  = state_q == XFER && shift_end;
        state_d   = state_q == IDLE ? (start ? XFER : IDLE)
                  : state_q == XFER ? (byte_end && last_byte ? DONE : XFER) : IDLE;
        sel_d     = start ? sensor_select : sel_q;
        nbytes_d  = start ? write_count_bytes : nbytes_q;
        byte_d    = start ? 3'd0 : byte_end ? byte_q + 3'd1 : byte_q;
        load      = start || (byte_end && !last_byte);
        // SCLK falls on XFER entry, then toggles every cycle, and rests high otherwise.
        sclk_d    = state_d != XFER || (state_q == XFER && !phase_b);
        ss_g_d    = !(state_d == XFER && sel_d == SENSOR_GYRO);
        ss_a_d    = !(state_d == XFER && sel_d == SENSOR_ACCL);
        // Byte 0 answers the command byte and is dropped.
        rready_d  = byte_end && byte_q != 3'd0;
        rdata_d   = rready_d ? rx : rdata_q;
    end

    always_ff @(posedge div_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= SENSOR_GYRO;
            nbytes_q <= '0;
            byte_q   <= '0;
            sclk_q   <= 1'b1;
            ss_g_q   <= 1'b1;
            ss_a_q   <= 1'b1;
            rready_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            nbytes_q <= nbytes_d;
            byte_q   <= byte_d;
            sclk_q   <= sclk_d;
            ss_g_q   <= ss_g_d;
            ss_a_q   <= ss_a_d;
            rready_q <= rready_d;
            rdata_q  <= rdata_d;
        end
    end

    assign miso = sel_q == SENSOR_ACCL ? MISO_A : MISO_G;

    spi_shift_byte u_shift (
        .clk_i      (div_clk),
        .rst_i      (reset),
        .load_i     (load),
        .step_i     (state_q == XFER),
        .miso_i     (miso),
        .data_i     (write_data),
        .mosi_o     (MOSI),
        .phase_b_o  (phase_b),
        .byte_end_o (shift_end),
        .rx_o       (rx)
    );

    assign write_ready = state_q == IDLE;
    assign read_ready  = rready_q;
    assign read_data   = rdata_q;
    assign SCLK        = sclk_q;
    assign SS_G        = ss_g_q;
    assign SS_A        = ss_a_q;
endmodule

// File: tb/tb_spi_sensor_master.sv
// tb_spi_sensor_master: randomized scoreboard bench with a byte-level sensor model.
module tb_spi_sensor_master;
    logic       div_clk = 1'b0, reset = 1'b1, sensor_select = 1'b0, write_start = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic [2:0] write_count_bytes = 3'd0;
    logic       write_ready, read_ready, SCLK, MOSI, MISO_G, SS_G, MISO_A, SS_A;
    logic [7:0] read_data;

    int vectors = 0, errors = 0;

    always #5 div_clk = ~div_clk;

    spi_sensor_master dut (
        .div_clk(div_clk), .reset(reset), .sensor_select(sensor_select),
        .write_start(write_start), .write_data(write_data),
        .write_count_bytes(write_count_bytes), .write_ready(write_ready),
        .read_ready(read_ready), .read_data(read_data), .SCLK(SCLK), .MOSI(MOSI),
        .MISO_G(MISO_G), .SS_G(SS_G), .MISO_A(MISO_A), .SS_A(SS_A)
    );

    typedef struct {bit sel; int len;} win_t;

    logic [7:0] rd_arr [8];
    logic [7:0] exp_rd [$];
    bit         exp_mosi [$];
    win_t       exp_win [$];
    bit         cur_sel = 1'b0, noise = 1'b0;
    int         idx = 0;
    logic       miso_bit;

    // Sensor model: the selected sensor presents its reply bits in order, one per SCLK period.
    always_comb miso_bit = idx < 64 ? rd_arr[idx / 8][7 - idx % 8] : 1'b0;
    assign MISO_G = cur_sel ? noise : miso_bit;
    assign MISO_A = cur_sel ? miso_bit : noise;
    always @(posedge div_clk) noise <= 1'($urandom);

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name);
        vectors++;
        errors++;
        $display("FAIL %s: got unexpected event expected none", name);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a bit, a byte or a closed SS window.
    int  len = 0;
    bit  win_sel = 1'b0, other_low = 1'b0, sclk_prev = 1'b1;
    always @(negedge div_clk) begin
        #1;
        if (!SS_G || !SS_A) begin
            if (len == 0) begin
                win_sel   = SS_G;
                other_low = 1'b0;
            end
            other_low = other_low | (win_sel ? !SS_G : !SS_A);
            len++;
            if (SCLK && !sclk_prev) begin
                if (exp_mosi.size() == 0) unexpected("mosi_bit");
                else chk("mosi_bit", int'(MOSI), int'(exp_mosi.pop_front()));
                idx++;
            end
        end else begin
            if (len != 0 && !reset) begin
                if (exp_win.size() == 0) unexpected("ss_window");
                else begin
                    win_t w;
                    w = exp_win.pop_front();
                    chk("ss_len", len, w.len);
                    chk("ss_sel", int'(win_sel), int'(w.sel));
                    chk("ss_other_high", int'(other_low), 0);
                end
            end
            len = 0;
            idx = 0;
        end
        if (read_ready) begin
            if (exp_rd.size() == 0) unexpected("read_ready");
            else chk("read_data", int'(read_data), int'(exp_rd.pop_front()));
        end
        sclk_prev = SCLK;
    end

    // Caller must be at a negedge; the start is presented immediately.
    task automatic xfer(input bit sel, input int n, input int abort_at, input bit repulse,
                        input int wfix, input int rfix);
        logic [7:0] wd [8];
        win_t w;
        int cyc;
        for (int k = 0; k < n; k++) begin
            wd[k]     = wfix < 0 ? 8'($urandom) : wfix[7:0];
            rd_arr[k] = rfix < 0 ? 8'($urandom) : rfix[7:0];
            for (int b = 7; b >= 0; b--) exp_mosi.push_back(wd[k][b]);
            if (k > 0) exp_rd.push_back(rd_arr[k]);
        end
        w.sel = sel;
        w.len = 16 * n;
        exp_win.push_back(w);
        cur_sel           = sel;
        sensor_select     = sel;
        write_count_bytes = 3'(n);
        write_data        = wd[0];
        write_start       = 1'b1;
        cyc = 0;
        do begin
            @(negedge div_clk);
            cyc++;
            write_start = 1'b0;
            if (repulse && cyc == 5) begin
                write_start       = 1'b1;
                sensor_select     = ~sel;
                write_count_bytes = 3'($urandom_range(1, 7));
            end
            if (cyc % 16 == 1 && cyc / 16 + 1 < n) write_data = wd[cyc / 16 + 1];
            if (abort_at > 0 && cyc == abort_at) begin
                reset = 1'b1;
                @(negedge div_clk);
                chk("abort_ss_g", int'(SS_G), 1);
                chk("abort_ss_a", int'(SS_A), 1);
                chk("abort_sclk", int'(SCLK), 1);
                chk("abort_write_ready", int'(write_ready), 1);
                chk("abort_read_ready", int'(read_ready), 0);
                chk("abort_read_data", int'(read_data), 0);
                exp_rd.delete();
                exp_mosi.delete();
                exp_win.delete();
                @(negedge div_clk);
                reset = 1'b0;
                return;
            end
        end while (!write_ready && cyc < 200);
        chk("ready_latency", cyc, 16 * n + 2);
    endtask

    initial begin
        bit idle_ok;
        repeat (3) @(negedge div_clk);
        chk("rst_ss_g", int'(SS_G), 1);
        chk("rst_ss_a", int'(SS_A), 1);
        chk("rst_sclk", int'(SCLK), 1);
        chk("rst_mosi", int'(MOSI), 0);
        chk("rst_write_ready", int'(write_ready), 1);
        chk("rst_read_ready", int'(read_ready), 0);
        chk("rst_read_data", int'(read_data), 0);
        reset = 1'b0;
        @(negedge div_clk);

        xfer(1'b0, 2, 0, 1'b0, 'hAA, 'h5C);
        xfer(1'b1, 5, 0, 1'b0, 'hFF, 'hA5);

        sensor_select     = 1'b1;
        write_count_bytes = 3'd0;
        write_start       = 1'b1;
        idle_ok           = 1'b1;
        repeat (20) begin
            @(negedge div_clk);
            write_start = 1'b0;
            idle_ok = idle_ok & SS_G & SS_A & SCLK & write_ready;
        end
        chk("count0_idle", int'(idle_ok), 1);

        xfer(1'b1, 1, 0, 1'b0, -1, -1);
        xfer(1'b0, 4, 0, 1'b1, -1, -1);
        xfer(1'b1, 3, 0, 1'b1, -1, -1);
        xfer(1'b0, 3, 25, 1'b0, -1, -1);
        xfer(1'b0, 2, 0, 1'b0, -1, -1);
        xfer(1'b1, 3, 0, 1'b0, -1, -1);
        repeat (15) xfer(1'($urandom), $urandom_range(1, 7), 0, 1'($urandom), -1, -1);

        repeat (4) @(negedge div_clk);
        chk("queues_empty", exp_rd.size() + exp_mosi.size() + exp_win.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
